vga_image_renderer: RTL
=======================

// Module: vga_image_renderer
//
// PURPOSE
// - Pixel stage directly downstream of the VGA timing generator. Consumes its raw counters
//   (posx/posy, counting from the sync pulse) and active-low syncs; emits 8-bit RGB.
// - Centres an IMG_W x IMG_H 8-bit grayscale image (the decrypted RSA output) in the active area.
// - Reads the image through a 1-cycle synchronous-read memory port; delays syncs to match.
//
// PARAMETERS
// - H_OFFSET  10'd144 : posx of first active column (HSYN+HBP)
// - V_OFFSET  10'd33  : posy of first active line (VSYN+VBP)
// - ACT_W     10'd640 : active width, pixels
// - ACT_H     10'd480 : active height, lines
// - IMG_X     10'd192 : image left edge, relative to active origin
// - IMG_Y     10'd112 : image top edge, relative to active origin
// - IMG_W     10'd256 : image width, pixels
// - IMG_H     10'd256 : image height, lines
// - ADDR_W    16      : memory address width; requires IMG_W*IMG_H <= 2**ADDR_W
// - BG_COLOR  8'h00   : gray level outside image / when image disabled
//
// PORTS
// - clk         in   1       pixel clock (same clock as timing generator)
// - rst         in   1       synchronous, active-high reset
// - posx        in   10      horizontal counter from timing generator
// - posy        in   10      vertical counter from timing generator
// - h_sync_in   in   1       active-low hsync from timing generator
// - v_sync_in   in   1       active-low vsync from timing generator
// - img_en      in   1       show image; sampled only at frame start
// - mem_addr    out  ADDR_W  image read address (registered)
// - mem_rd      out  1       read strobe; high while mem_addr is a valid image pixel
// - mem_data    in   8       read data, valid exactly 1 clk after mem_addr/mem_rd
// - vga_r/g/b   out  8 each  pixel colour; grayscale, r=g=b
// - vga_hs      out  1       delayed h_sync_in
// - vga_vs      out  1       delayed v_sync_in
// - vga_blank_n out  1       high inside ACT_W x ACT_H window (own decode, not the timing generator's Blank_n)
// - frame_start out  1       1-clk pulse, registered, when posx==0 && posy==0
//
// BEHAVIOUR
// - Reset values: rgb=0, vga_hs=1, vga_vs=1, vga_blank_n=0, mem_addr=0, mem_rd=0, frame_start=0;
//   all pipeline flags, line_base and img_en_q cleared.
// - Fixed 3-clk pipeline; all outputs at T+3 belong to posx/posy presented at T:
//   - S1 (T+1): register mem_addr, mem_rd, in_act, in_img, syncs.
//   - S2 (T+2): memory returns mem_data; flags and syncs advance.
//   - S3 (T+3): output register.
// - Window decode: in_act = posx in [H_OFFSET, H_OFFSET+ACT_W) && posy in [V_OFFSET, V_OFFSET+ACT_H).
// - in_img = same test against the image rectangle offset by IMG_X/IMG_Y, further gated by img_en_q.
// - Address generation uses no multiplier:
//   - mem_addr = line_base + (posx - (H_OFFSET+IMG_X)).
//   - line_base is cleared at frame start.
//   - line_base += IMG_W on the clk where posx == H_OFFSET+IMG_X+IMG_W-1 on an image line.
//   - Last image pixel reads IMG_W*IMG_H-1; the count never wraps within a frame.
// - mem_rd=1 only when in_img; mem_addr holds its last value otherwise.
// - Output colour: in_img -> mem_data; in_act && !in_img -> BG_COLOR; !in_act -> 0 (blanking must be black).
// - img_en is latched into img_en_q when posx==0 && posy==0. Toggling mid-frame has no effect
//   until the next frame (no tearing).
// - Reset mid-frame: pipeline flushed, img_en_q=0. BG/black is shown until the next frame start,
//   then normal operation resumes.
// - posx/posy out of range (>= HMAX/VMAX): treated as outside both windows; no memory read.
//
// CONFIGURATION
// - BORDER_EN defined:
//   - Pixels in the 1-pixel ring directly outside the image rectangle (inside the active area)
//     output 8'hFF while img_en_q=1.
//   - The ring never issues mem_rd.
// - BORDER_EN undefined: the ring shows BG_COLOR; no border logic is synthesised.
//
// TESTING
// - Image origin: posx=336, posy=145, img_en=1 from frame start -> mem_addr=0, mem_rd=1 at T+1;
//   mem_data=8'h5A -> rgb=5A/5A/5A, vga_blank_n=1 at T+3.
// - Row wrap: posx=591, posy=145 -> addr 255; posx=336, posy=146 -> addr 256;
//   posx=591, posy=400 -> addr 65535.
// - Outside image: posx=200, posy=40 -> mem_rd=0, rgb=BG_COLOR.
//   posx=10, posy=10 -> rgb=0, vga_blank_n=0, vga_hs equals h_sync_in delayed 3 clks.
// - img_en: drop to 0 mid-frame -> image persists to frame end; next frame is all BG with mem_rd
//   never asserted. Raise again -> image returns only after the following frame_start.
// - Reset: assert rst 1 clk at posx=400, posy=200 -> next clk all outputs at reset values;
//   no mem_rd until the next frame_start.
// - BORDER_EN: posx=335, posy=200 -> rgb=FF, mem_rd=0. Without the macro -> rgb=BG_COLOR.

Source files
------------

// File: rtl/vga_image_renderer.sv
// vga_image_renderer: 3-stage pixel pipeline centring a grayscale image, read from a
// 1-cycle sync-read memory, inside the VGA active area. Define BORDER_EN for a white 1-px frame.
module vga_image_renderer #(
  parameter logic [9:0]  H_OFFSET = 10'd144,
  parameter logic [9:0]  V_OFFSET = 10'd33,
  parameter logic [9:0]  ACT_W    = 10'd640,
  parameter logic [9:0]  ACT_H    = 10'd480,
  parameter logic [9:0]  IMG_X    = 10'd192,
  parameter logic [9:0]  IMG_Y    = 10'd112,
  parameter logic [9:0]  IMG_W    = 10'd256,
  parameter logic [9:0]  IMG_H    = 10'd256,
  parameter int unsigned ADDR_W   = 16,
  parameter logic [7:0]  BG_COLOR = 8'h00
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [9:0]        posx,
  input  logic [9:0]        posy,
  input  logic              h_sync_in,
  input  logic              v_sync_in,
  input  logic              img_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [7:0]        mem_data,
  output logic [7:0]        vga_r,
  output logic [7:0]        vga_g,
  output logic [7:0]        vga_b,
  output logic              vga_hs,
  output logic              vga_vs,
  output logic              vga_blank_n,
  output logic              frame_start
);

  localparam logic [9:0] ACT_X1 = H_OFFSET + ACT_W;
  localparam logic [9:0] ACT_Y1 = V_OFFSET + ACT_H;
  localparam logic [9:0] IMG_X0 = H_OFFSET + IMG_X;
  localparam logic [9:0] IMG_Y0 = V_OFFSET + IMG_Y;
  localparam logic [9:0] IMG_X1 = IMG_X0 + IMG_W;
  localparam logic [9:0] IMG_Y1 = IMG_Y0 + IMG_H;
  localparam logic [9:0] IMG_XL = IMG_X1 - 10'd1;

  logic              origin, act_d, rect_d, img_d;
  logic [9:0]        col;
  logic [ADDR_W-1:0] line_base_d, line_base_q, mem_addr_d, mem_addr_q;
  logic              img_en_q, mem_rd_q;
  logic              act1_q, img1_q, hs1_q, vs1_q, fs1_q;
  logic              act2_q, img2_q, hs2_q, vs2_q, fs2_q;
  logic [7:0]        pix_d, pix_q;
  logic              hs3_q, vs3_q, blank_q, fs3_q;

  // Address is line_base plus column offset; line_base steps by IMG_W on each line's last pixel.
  always_comb begin
    origin = (posx == '0) && (posy == '0);
    act_d  = (posx >= H_OFFSET) && (posx < ACT_X1) && (posy >= V_OFFSET) && (posy < ACT_Y1);
    rect_d = (posx >= IMG_X0) && (posx < IMG_X1) && (posy >= IMG_Y0) && (posy < IMG_Y1);
    img_d  = rect_d && img_en_q;
    col    = posx - IMG_X0;
    mem_addr_d  = img_d ? line_base_q + ADDR_W'(col) : mem_addr_q;
    line_base_d = line_base_q;
    if (origin) begin
      line_base_d = '0;
    end else if (img_d && (posx == IMG_XL)) begin
      line_base_d = line_base_q + ADDR_W'(IMG_W);
    end
  end

`ifdef BORDER_EN
  localparam logic [9:0] IMG_XB0 = IMG_X0 - 10'd1;
  localparam logic [9:0] IMG_YB0 = IMG_Y0 - 10'd1;

  logic brd_d, brd1_q, brd2_q;

  always_comb begin
    brd_d = img_en_q && act_d && !rect_d &&
            (posx >= IMG_XB0) && (posx <= IMG_X1) && (posy >= IMG_YB0) && (posy <= IMG_Y1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      brd1_q <= 1'b0;
      brd2_q <= 1'b0;
    end else begin
      brd1_q <= brd_d;
      brd2_q <= brd1_q;
    end
  end

  always_comb begin
    pix_d = img2_q ? mem_data : (act2_q ? (brd2_q ? 8'hFF : BG_COLOR) : '0);
  end
`else
  always_comb begin
    pix_d = img2_q ? mem_data : (act2_q ? BG_COLOR : '0);
  end
`endif

  // frame_start rides the same 3-stage pipe so every output refers to one input pixel.
  always_ff @(posedge clk) begin
    if (rst) begin
      line_base_q <= '0;
      mem_addr_q  <= '0;
      mem_rd_q    <= 1'b0;
      img_en_q    <= 1'b0;
      act1_q      <= 1'b0;
      img1_q      <= 1'b0;
      hs1_q       <= 1'b1;
      vs1_q       <= 1'b1;
      fs1_q       <= 1'b0;
      act2_q      <= 1'b0;
      img2_q      <= 1'b0;
      hs2_q       <= 1'b1;
      vs2_q       <= 1'b1;
      fs2_q       <= 1'b0;
      pix_q       <= '0;
      hs3_q       <= 1'b1;
      vs3_q       <= 1'b1;
      blank_q     <= 1'b0;
      fs3_q       <= 1'b0;
    end else begin
      if (origin) begin
        img_en_q <= img_en;
      end
      line_base_q <= line_base_d;
      mem_addr_q  <= mem_addr_d;
      mem_rd_q    <= img_d;
      act1_q      <= act_d;
      img1_q      <= img_d;
      hs1_q       <= h_sync_in;
      vs1_q       <= v_sync_in;
      fs1_q       <= origin;
      act2_q      <= act1_q;
      img2_q      <= img1_q;
      hs2_q       <= hs1_q;
      vs2_q       <= vs1_q;
      fs2_q       <= fs1_q;
      pix_q       <= pix_d;
      hs3_q       <= hs2_q;
      vs3_q       <= vs2_q;
      blank_q     <= act2_q;
      fs3_q       <= fs2_q;
    end
  end

  assign mem_addr    = mem_addr_q;
  assign mem_rd      = mem_rd_q;
  assign vga_r       = pix_q;
  assign vga_g       = pix_q;
  assign vga_b       = pix_q;
  assign vga_hs      = hs3_q;
  assign vga_vs      = vs3_q;
  assign vga_blank_n = blank_q;
  assign frame_start = fs3_q;

endmodule
